instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
- Fetch sequencer for the single-cycle-read instruction memory.
- Owns the program counter and drives the word-aligned fetch address.
- Captures each returned instruction word, with its PC, into a small FIFO queue and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus PC reload), back-pressure, and out-of-range fetch faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, fetch queue entries; power of two, at least 2.
- MEM_WORDS, 32, instruction memory size in 32-bit words; valid fetch range is PC < MEM_WORDS*4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  allows new fetches when high.
- redirect_valid  in  1  one-cycle redirect request (taken branch or jump).
- redirect_pc  in  32  redirect target address.
- imem_addr  out  32  byte address to instruction memory; equals pc_q.
- imem_rdata  in  32  instruction word; combinational function of imem_addr, same cycle.
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  PC of the head instruction.
- queue_count  out  clog2(DEPTH)+1  number of occupied entries.
- fetch_fault  out  1  sticky flag: a fetch was attempted at PC >= MEM_WORDS*4.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - pc_q = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, read/write pointers = 0, all queue storage = 0.
  - inst_valid = 0, inst_data = 0, inst_pc = 0, queue_count = 0, fetch_fault = 0.
- Reset mid-operation discards all queued entries immediately.
- Pop:
  - pop = inst_valid & inst_ready.
  - inst_valid = (count != 0).
  - inst_data and inst_pc show the head entry directly from storage, with no extra register stage.
- Fetch fire condition:
  - fire = fetch_en & !redirect_valid & !fetch_fault & in_range & (count < DEPTH | pop)
  - in_range = (pc_q < MEM_WORDS*4).
  - A push into a full queue is allowed only when a pop occurs in the same cycle.
- On fire:
  - Write {pc_q, imem_rdata} at the write pointer.
  - Advance the write pointer modulo DEPTH.
  - pc_q <= pc_q + 4, 32-bit wrap.
- Fault:
  - If fetch_en & !redirect_valid & !fetch_fault & !in_range, set fetch_fault <= 1.
  - No push and pc_q holds.
  - fetch_fault stays high until reset or a redirect.
  - The queue continues to drain normally while faulted.
- Redirect (highest priority):
  - count <= 0 and both pointers <= 0; the whole queue is flushed.
  - pc_q <= {redirect_pc[31:2], 2'b00}; misaligned low bits are silently forced to zero.
  - fetch_fault <= 0.
  - No fetch fires that cycle.
  - A pop handshake in the same cycle still counts as consumed by decode; the flush then clears the rest.
- Count update when not redirecting: count <= count + fire - pop. Simultaneous push and pop leaves count unchanged.
- Latency: a word addressed by pc_q in cycle N appears at the head no earlier than cycle N+1.
  - With an empty queue, inst_valid rises in N+1.
  - Steady-state throughput is 1 instruction/cycle while inst_ready = 1.
- fetch_en low: the PC holds and no pushes occur; draining continues.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Storage order is preserved across wrap.
- No X propagation:
  - inst_data and inst_pc show storage contents even when inst_valid = 0.
  - Storage is reset to 0, so these outputs are never X.

Test Plan:
- Reset, then fetch_en = 1 and inst_ready = 1, memory word i = 32'h1000_0000+i
  -> inst_valid rises one cycle after reset release.
  -> inst_pc = 0, 4, 8, … on consecutive cycles, with inst_data matching.
  -> queue_count stays 1.
- inst_ready = 0 with fetch_en = 1
  -> queue_count climbs to 4 and pc_q stops at 16.
  -> Then inst_ready = 1 for one cycle: pop plus push in the same cycle, count stays 4, pc_q = 20.
- Redirect to 32'h0000_0042 while 3 entries are queued
  -> next cycle count = 0, imem_addr = 32'h40.
  -> The following cycle the head is inst_pc = 32'h40.
  -> An entry popped in the redirect cycle counts as delivered.
- Sequential fetch up to 124 with MEM_WORDS = 32
  -> the fetch at 128 sets fetch_fault = 1, pc_q holds at 128.
  -> The queue drains to 0 and fetch_fault stays 1.
  -> A redirect to 0 clears fetch_fault and fetching resumes.
- Fill to count 4 and wrap the pointers over 3 full cycles of the queue
  -> the output PC sequence stays strictly increasing by 4 with no duplicates or drops.
- Assert rst_n low mid-stream between clock edges
  -> inst_valid, queue_count and fetch_fault go to 0 and imem_addr goes to RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer feeding a small fetch queue with redirect and fault handling
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [31:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     fetch_fault
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  logic [31:0]   pc_q;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          pop, in_range, try_fetch, fire, fault_set;
  assign imem_addr   = pc_q;
  assign inst_valid  = count != '0;
  assign inst_data   = data_mem[rd_ptr];
  assign inst_pc     = pc_mem[rd_ptr];
  assign queue_count = count;
  // fetch/pop decisions; a full queue may still accept a word when the head leaves this cycle
  always_comb begin
    in_range  = {1'b0, pc_q} < LIMIT;
    pop       = inst_valid & inst_ready;
    try_fetch = fetch_en & ~redirect_valid & ~fetch_fault;
    fire      = try_fetch & in_range & ((count < FULL) | pop);
    fault_set = try_fetch & ~in_range;
  end
  // PC, pointers, occupancy and sticky fault; a redirect flushes everything and wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc_q        <= {redirect_pc[31:2], 2'b00};
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_fault <= 1'b0;
    end else begin
      if (fire) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (fault_set) fetch_fault <= 1'b1;
      count <= count + (AW+1)'(fire) - (AW+1)'(pop);
    end
  end
  // queue storage, cleared on reset so the head outputs are never unknown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (fire) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= pc_q;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench with a queue-based reference model of the fetch unit
module tb_instr_fetch_ctrl;
  localparam int DEPTH = 4;
  localparam int MEM_WORDS = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fetch_en = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, inst_data, inst_pc;
  logic inst_valid, fetch_fault;
  logic [$clog2(DEPTH):0] queue_count;
  int vectors = 0, errors = 0;
  logic mon_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = RESET_PC;
  logic m_fault = 1'b0;
  logic p_fire = 1'b0, p_red = 1'b0, p_fset = 1'b0;
  logic [31:0] p_rpc = '0;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .queue_count(queue_count), .fetch_fault(fetch_fault));

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = memw(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // apply the effect of the previous cycle's decision to the model
  task automatic settle();
    if (p_red) begin
      exp_q.delete();
      m_pc = {p_rpc[31:2], 2'b00};
      m_fault = 1'b0;
    end else begin
      if (p_fire) begin
        exp_q.push_back({m_pc, memw(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (p_fset) m_fault = 1'b1;
    end
  endtask

  task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic pop, inr;
    @(posedge clk); #1;
    settle();
    fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; inst_ready = rdy;
    pop = rdy && exp_q.size() != 0;
    inr = m_pc < MEM_WORDS * 4;
    p_red = rv; p_rpc = rpc;
    p_fire = fe && !rv && !m_fault && inr && (exp_q.size() < DEPTH || pop);
    p_fset = fe && !rv && !m_fault && !inr;
  endtask

  // monitor: compare DUT outputs to the model and retire popped entries
  always @(negedge clk) begin
    if (mon_en) begin
      chk("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
      chk("queue_count", 32'(queue_count), 32'(exp_q.size()));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("imem_addr", imem_addr, m_pc);
      if (exp_q.size() != 0) begin
        chk("inst_pc", inst_pc, exp_q[0][63:32]);
        chk("inst_data", inst_data, exp_q[0][31:0]);
        if (inst_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst inst_valid", 32'(inst_valid), 32'h0);
    chk("rst queue_count", 32'(queue_count), 32'h0);
    chk("rst fetch_fault", 32'(fetch_fault), 32'h0);
    chk("rst imem_addr", imem_addr, RESET_PC);
    chk("rst inst_data", inst_data, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 32'h42, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(1, 1, 32'h70, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           32'($urandom_range(0, 36)) * 4 + 32'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    fetch_en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    chk("async inst_valid", 32'(inst_valid), 32'h0);
    chk("async queue_count", 32'(queue_count), 32'h0);
    chk("async fetch_fault", 32'(fetch_fault), 32'h0);
    chk("async imem_addr", imem_addr, RESET_PC);
    @(negedge clk); #2;
    rst_n = 1'b1;
    exp_q.delete();
    m_pc = RESET_PC; m_fault = 1'b0;
    p_fire = 1'b0; p_red = 1'b0; p_fset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           32'($urandom_range(0, 36)) * 4, $urandom_range(0, 9) < 6);
    @(posedge clk); #1;
    settle();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
